// File: rtl/register_write_arbiter.sv
// Register-file write port arbiter: clears x1..x31 after reset, then round-robins
// between the execute (A) and load (B) writeback requesters with one registered write per cycle.
module register_write_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      aValid,
    input  logic [REG_ADDR_WIDTH-1:0] aReg,
    input  logic [DATA_WIDTH-1:0]     aData,
    output logic                      aReady,
    input  logic                      bValid,
    input  logic [REG_ADDR_WIDTH-1:0] bReg,
    input  logic [DATA_WIDTH-1:0]     bData,
    output logic                      bReady,
    output logic                      writeEnable,
    output logic [REG_ADDR_WIDTH-1:0] desRegister,
    output logic [DATA_WIDTH-1:0]     writeData,
    output logic                      clearBusy,
    output logic [15:0]               stallCount
);

    typedef enum logic {CLEAR, ARB} stateT;
    typedef enum logic {PTR_A, PTR_B} ptrT;

    localparam logic [REG_ADDR_WIDTH-1:0] FIRST_INDEX = REG_ADDR_WIDTH'(1);
    localparam logic [REG_ADDR_WIDTH-1:0] LAST_INDEX  = '1;
    localparam logic [15:0]               STALL_MAX   = 16'hFFFF;

    stateT                     state, stateNext;
    ptrT                       rrPtr, rrPtrNext;
    logic [REG_ADDR_WIDTH-1:0] clearIndex, clearIndexNext;
    logic                      writeEnableNext;
    logic [REG_ADDR_WIDTH-1:0] desRegisterNext;
    logic [DATA_WIDTH-1:0]     writeDataNext;
    logic [15:0]               stallCountNext;

    assign clearBusy = (state == CLEAR);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it
        // unassigned; a missing default would infer a latch.
        stateNext       = state;
        rrPtrNext       = rrPtr;
        clearIndexNext  = clearIndex;
        writeEnableNext = 1'b0;
        desRegisterNext = desRegister;
        writeDataNext   = writeData;
        stallCountNext  = stallCount;
        aReady          = 1'b0;
        bReady          = 1'b0;

        case (state)
            CLEAR: begin
                writeEnableNext = 1'b1;
                desRegisterNext = clearIndex;
                writeDataNext   = '0;
                clearIndexNext  = clearIndex + FIRST_INDEX;
                if (clearIndex == LAST_INDEX) begin
                    stateNext = ARB;
                end
            end
            ARB: begin
                // A wins unless B also asks and the pointer favours B.
                aReady = aValid && (!bValid || rrPtr == PTR_A);
                bReady = bValid && !aReady;
                if (aReady) begin
                    writeEnableNext = (aReg != '0);
                    if (aReg != '0) begin
                        desRegisterNext = aReg;
                        writeDataNext   = aData;
                    end
                    rrPtrNext = PTR_B;
                end else if (bReady) begin
                    writeEnableNext = (bReg != '0);
                    if (bReg != '0) begin
                        desRegisterNext = bReg;
                        writeDataNext   = bData;
                    end
                    rrPtrNext = PTR_A;
                end
                if (((aValid && !aReady) || (bValid && !bReady)) && stallCount != STALL_MAX) begin
                    stallCountNext = stallCount + 16'd1;
                end
            end
            default: stateNext = CLEAR;
        endcase

        // Nothing is accepted while reset is held: any grant would be discarded anyway.
        if (reset) begin
            aReady = 1'b0;
            bReady = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CLEAR;
            rrPtr       <= PTR_A;
            clearIndex  <= FIRST_INDEX;
            writeEnable <= 1'b0;
            desRegister <= '0;
            writeData   <= '0;
            stallCount  <= '0;
        end else begin
            state       <= stateNext;
            rrPtr       <= rrPtrNext;
            clearIndex  <= clearIndexNext;
            writeEnable <= writeEnableNext;
            desRegister <= desRegisterNext;
            writeData   <= writeDataNext;
            stallCount  <= stallCountNext;
        end
    end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Self-checking bench for register_write_arbiter: a behavioural model tracks the
// expected outputs each cycle, with directed scenarios plus constrained-random traffic.
module tb_register_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        aValid, bValid;
    logic [4:0]  aReg, bReg;
    logic [31:0] aData, bData;
    logic        aReady, bReady;
    logic        writeEnable;
    logic [4:0]  desRegister;
    logic [31:0] writeData;
    logic        clearBusy;
    logic [15:0] stallCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_write_arbiter #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .aValid(aValid), .aReg(aReg), .aData(aData), .aReady(aReady),
        .bValid(bValid), .bReg(bReg), .bData(bData), .bReady(bReady),
        .writeEnable(writeEnable), .desRegister(desRegister), .writeData(writeData),
        .clearBusy(clearBusy), .stallCount(stallCount)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining clear writes, who is favoured on a tie, and the
    // values the registered outputs must show after the most recent edge.
    bit          mValid = 1'b0;
    int          mClearNext = 1;
    bit          mFavorB = 1'b0;
    bit          mWe = 1'b0;
    int          mDes = 0;
    logic [31:0] mData = '0;
    int          mStall = 0;
    bit          mGrantA = 1'b0, mGrantB = 1'b0;
    int          waitA = 0, waitB = 0;

    function automatic bit expGrantA();
        return !reset && mClearNext > 31 && aValid && (!bValid || !mFavorB);
    endfunction

    function automatic bit expGrantB();
        return !reset && mClearNext > 31 && bValid && (!aValid || mFavorB);
    endfunction

    always @(posedge clk) begin : model
        bit ga, gb;
        ga = expGrantA();
        gb = expGrantB();
        if (reset) begin
            mValid = 1'b1; mClearNext = 1; mFavorB = 1'b0;
            mWe = 1'b0; mDes = 0; mData = '0; mStall = 0;
        end else if (mValid) begin
            if (mClearNext <= 31) begin
                mWe = 1'b1; mDes = mClearNext; mData = '0;
                mClearNext++;
            end else begin
                mWe = 1'b0;
                if (ga) begin
                    if (aReg != 0) begin mWe = 1'b1; mDes = int'(aReg); mData = aData; end
                    mFavorB = 1'b1;
                end else if (gb) begin
                    if (bReg != 0) begin mWe = 1'b1; mDes = int'(bReg); mData = bData; end
                    mFavorB = 1'b0;
                end
                if ((aValid && !ga) || (bValid && !gb))
                    mStall = (mStall == 65535) ? 65535 : mStall + 1;
            end
        end
        mGrantA = ga;
        mGrantB = gb;
    end

    always @(negedge clk) begin
        if (mValid) begin
            check("aReady", 32'(aReady), 32'(expGrantA()));
            check("bReady", 32'(bReady), 32'(expGrantB()));
            check("writeEnable", 32'(writeEnable), 32'(mWe));
            check("desRegister", 32'(desRegister), mDes);
            check("writeData", writeData, mData);
            check("clearBusy", 32'(clearBusy), 32'(mClearNext <= 31));
            check("stallCount", 32'(stallCount), mStall);
            if (!reset && mClearNext > 31) begin
                waitA = (aValid && !aReady) ? waitA + 1 : 0;
                waitB = (bValid && !bReady) ? waitB + 1 : 0;
                check("aWaitBound", 32'(waitA <= 1), 32'd1);
                check("bWaitBound", 32'(waitB <= 1), 32'd1);
            end else begin
                waitA = 0;
                waitB = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setA(input bit v, input int r, input logic [31:0] d);
        aValid = v; aReg = 5'(r); aData = d;
    endtask

    task automatic setB(input bit v, input int r, input logic [31:0] d);
        bValid = v; bReg = 5'(r); bData = d;
    endtask

    initial begin
        reset = 1'b1;
        setA(0, 0, 0);
        setB(0, 0, 0);

        // Reset for two cycles, then the 31-write clear sequence with requesters knocking.
        tick(2);
        check("rstBusy", 32'(clearBusy), 32'd1);
        check("rstWe", 32'(writeEnable), 32'd0);
        reset = 1'b0;
        tick(1);
        check("clr1We", 32'(writeEnable), 32'd1);
        check("clr1Des", 32'(desRegister), 32'd1);
        setA(1, 9, 32'h9999);
        setB(1, 8, 32'h8888);
        tick(29);
        check("clr30Des", 32'(desRegister), 32'd30);
        setA(0, 0, 0);
        setB(0, 0, 0);
        tick(1);
        check("clr31Des", 32'(desRegister), 32'd31);
        check("clrDoneBusy", 32'(clearBusy), 32'd0);
        check("clrStall", 32'(stallCount), 32'd0);

        // A alone for three cycles.
        setA(1, 5, 32'h1234);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("aOnlyDes", 32'(desRegister), 32'd5);
            check("aOnlyData", writeData, 32'h1234);
        end
        setA(0, 0, 0);
        tick(1);
        check("aOnlyIdleWe", 32'(writeEnable), 32'd0);
        check("aOnlyStall", 32'(stallCount), 32'd0);

        // One B-only grant points the round robin back at A, then six contested cycles.
        setB(1, 7, 32'h7777);
        tick(1);
        check("bOnlyDes", 32'(desRegister), 32'd7);
        setA(1, 3, 32'hAAAA);
        setB(1, 4, 32'hBBBB);
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check("altDes", 32'(desRegister), (k % 2 == 0) ? 32'd3 : 32'd4);
            check("altData", writeData, (k % 2 == 0) ? 32'hAAAA : 32'hBBBB);
        end
        check("altStall", 32'(stallCount), 32'd6);
        setA(0, 0, 0);
        setB(0, 0, 0);
        tick(1);

        // Write to x0 is accepted but never reaches the register file.
        setA(1, 0, 32'hFFFF);
        #1;
        check("x0Ready", 32'(aReady), 32'd1);
        tick(1);
        check("x0We", 32'(writeEnable), 32'd0);
        setA(0, 0, 0);
        tick(1);

        // Random traffic; requesters hold their request until it is taken.
        for (int i = 0; i < 300; i++) begin
            if (!(aValid && !mGrantA)) begin
                aValid = 1'($urandom_range(0, 1)); aReg = 5'($urandom); aData = $urandom;
            end
            if (!(bValid && !mGrantB)) begin
                bValid = 1'($urandom_range(0, 1)); bReg = 5'($urandom); bData = $urandom;
            end
            tick(1);
        end

        // Reset from ARB with traffic in flight, then reset again part-way through clearing.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        setA(0, 0, 0);
        setB(0, 0, 0);
        tick(9);
        check("midClrDes", 32'(desRegister), 32'd9);
        reset = 1'b1;
        tick(1);
        check("midRstWe", 32'(writeEnable), 32'd0);
        reset = 1'b0;
        tick(1);
        check("restartDes", 32'(desRegister), 32'd1);
        check("restartStall", 32'(stallCount), 32'd0);
        tick(30);
        check("restartDoneDes", 32'(desRegister), 32'd31);
        setA(1, 12, 32'hC0C0);
        setB(1, 13, 32'hD0D0);
        #1;
        check("ptrResetA", 32'(aReady), 32'd1);
        check("ptrResetB", 32'(bReady), 32'd0);
        tick(1);
        check("ptrFirstDes", 32'(desRegister), 32'd12);
        tick(1);
        check("ptrSecondDes", 32'(desRegister), 32'd13);
        setA(0, 0, 0);
        setB(0, 0, 0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
